txdata_pkt_sched: RTL and testbench
===================================

TXDATA_PKT_SCHED -- requirements
Module: txdata_pkt_sched

Interface
REQ-001 SHALL have parameter PKT_LEN, default 48: valid beats per RBG packet (range 2..255).
REQ-002 SHALL have parameter RBG_NUM, default 16: RBG packets per symbol (range 1..16).
REQ-003 SHALL have parameter GAP_LEN, default 4: idle cycles between packets of one symbol (range 0..15).
REQ-004 SHALL have parameter SYMB_NUM, default 14: symbols per slot.
REQ-005 SHALL have parameter SLOT_NUM, default 80: slots per frame.
REQ-006 SHALL have port i_clk, input, 1 bit: the only clock.
REQ-007 SHALL have port i_reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port i_enable, input, 1 bit: scheduler enable.
REQ-009 SHALL have port i_sym_start, input, 1 bit: single-cycle pulse at the start of a symbol.
REQ-010 SHALL have port i_rready, input, 1 bit: downstream ready; beats advance only while it is high.
REQ-011 SHALL have port i_clr_err, input, 1 bit: clears the sticky overrun flag.
REQ-012 SHALL have port o_rbg_load, output, 1 bit: one-cycle pulse that loads the next RBG into the tx queues.
REQ-013 SHALL have ports o_rx_vld, o_rx_sop and o_rx_eop, each output, 1 bit: packet framing to the tx queues.
REQ-014 SHALL have port o_rbg_idx, output, 4 bits: current RBG index.
REQ-015 SHALL have port o_symb_idx, output, 4 bits: current symbol index.
REQ-016 SHALL have port o_slot_idx, output, 7 bits: current slot index.
REQ-017 SHALL have port o_busy, output, 1 bit: high in any state other than IDLE.
REQ-018 SHALL have port o_overrun, output, 1 bit: sticky flag for a symbol start that arrived while busy.

Function
REQ-019 SHALL implement the FSM states IDLE, LOAD, BURST and GAP; all outputs SHALL be registered.
REQ-020 IDLE -> LOAD SHALL occur when i_sym_start=1 and i_enable=1; i_sym_start while i_enable=0 SHALL be ignored and SHALL NOT set the overrun flag.
REQ-021 In LOAD, o_rbg_load SHALL be 1 for exactly one cycle; the FSM SHALL then go to BURST.
REQ-022 BURST timing:
- Latency: i_sym_start at cycle T gives o_rbg_load at T+1 and the first o_rx_vld/o_rx_sop at T+2.
- A beat counter (8-bit, 0..PKT_LEN-1) SHALL advance only on cycles where o_rx_vld=1.
REQ-023 BURST stall: o_rx_vld = i_rready (registered-path equivalent, asserted the same cycle the FSM is in BURST); while i_rready=0 the beat counter SHALL hold and o_rx_vld/o_rx_sop/o_rx_eop SHALL be 0; a stalled sop SHALL be re-presented on the first ready cycle.
REQ-024 o_rx_sop SHALL be high on beat 0 only; o_rx_eop SHALL be high on beat PKT_LEN-1 only.
REQ-025 After the eop beat:
- If o_rbg_idx < RBG_NUM-1 and i_enable=1: increment o_rbg_idx, then go to GAP (or straight to LOAD if GAP_LEN=0).
- Otherwise: go to IDLE.
REQ-026 GAP SHALL last exactly GAP_LEN cycles with all framing outputs at 0, then go to LOAD.
REQ-027 If i_enable falls mid-packet, the current packet SHALL complete through eop; the symbol SHALL then be abandoned (go to IDLE) with the symbol counter still advanced.
REQ-028 On entry to IDLE from BURST: o_rbg_idx SHALL reset to 0 and o_symb_idx SHALL increment.
REQ-029 At o_symb_idx = SYMB_NUM-1, the increment SHALL wrap o_symb_idx to 0 and increment o_slot_idx; o_slot_idx SHALL wrap from SLOT_NUM-1 to 0.
REQ-030 i_sym_start in any non-IDLE state SHALL set o_overrun=1 and SHALL otherwise be ignored (no restart, no queueing).
REQ-031 i_clr_err=1 SHALL clear o_overrun; if a set and a clear occur in the same cycle, the set SHALL win.
REQ-032 In every cycle, o_rx_sop and o_rx_eop SHALL each imply o_rx_vld.

Reset
REQ-033 While i_reset=1, the FSM SHALL be in IDLE and all outputs and counters SHALL be 0, including mid-packet; a packet interrupted by reset SHALL NOT be resumed.
REQ-034 The first cycle after reset deassertion SHALL accept i_sym_start.

Verification
REQ-035 The bench SHALL cover a nominal symbol: defaults, i_rready=1, pulse i_sym_start at T.
- Required: rbg_load at T+1, sop at T+2, eop at T+49, next rbg_load at T+54.
- Required: 16 packets of 48 beats (768 vld beats total), then IDLE with o_symb_idx=1.
REQ-036 The bench SHALL cover backpressure: drop i_rready for 5 cycles during beat 10.
- Required: vld=0 for those 5 cycles, beat count still exactly 48, eop delayed by 5 cycles.
REQ-037 The bench SHALL cover counter wrap: run 14 symbols, then run 14×80 symbols.
- Required: symb 13->0 with slot 0->1; slot 79->0 after the 1120th symbol.
REQ-038 The bench SHALL cover overrun: pulse i_sym_start during BURST of RBG 3.
- Required: o_overrun=1, schedule unaffected.
- Required: i_clr_err clears it; simultaneous set and clear leaves it at 1.
REQ-039 The bench SHALL cover enable drop: deassert i_enable at beat 20 of RBG 5.
- Required: RBG 5 finishes through eop, then IDLE with o_rbg_idx=0 and o_symb_idx incremented, and no further rbg_load.
REQ-040 The bench SHALL cover reset mid-burst: assert i_reset at beat 30.
- Required: next cycle all outputs 0 and IDLE.
- Required: the next i_sym_start yields rbg_load with o_rbg_idx=0.

Source files
------------

// File: rtl/txdata_pkt_sched.sv
// txdata_pkt_sched: schedules RBG packet bursts for each symbol of a slot.
//
// A symbol start pulse (while enabled) launches RBG_NUM packets. Each packet is
// a one-cycle o_rbg_load pulse followed by PKT_LEN framed beats. Beats advance
// only while i_rready is high. Consecutive packets are separated by GAP_LEN
// idle cycles. Symbol and slot counters advance each time a symbol ends.
//
// Ports
//   i_clk        clock
//   i_reset      synchronous active-high reset
//   i_enable     scheduler enable; a drop finishes the current packet, then
//                abandons the symbol
//   i_sym_start  single-cycle symbol start pulse
//   i_rready     downstream ready; a low cycle stalls the next beat
//   i_clr_err    clears the sticky overrun flag (a simultaneous set wins)
//   o_rbg_load   one-cycle load strobe for the next RBG
//   o_rx_vld     beat valid
//   o_rx_sop     first beat of a packet
//   o_rx_eop     last beat of a packet
//   o_rbg_idx    current RBG index
//   o_symb_idx   current symbol index
//   o_slot_idx   current slot index
//   o_busy       scheduler is not idle
//   o_overrun    sticky: a symbol start arrived while busy
module txdata_pkt_sched #(
  parameter int unsigned PKT_LEN  = 48,
  parameter int unsigned RBG_NUM  = 16,
  parameter int unsigned GAP_LEN  = 4,
  parameter int unsigned SYMB_NUM = 14,
  parameter int unsigned SLOT_NUM = 80
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic       i_sym_start,
  input  logic       i_rready,
  input  logic       i_clr_err,
  output logic       o_rbg_load,
  output logic       o_rx_vld,
  output logic       o_rx_sop,
  output logic       o_rx_eop,
  output logic [3:0] o_rbg_idx,
  output logic [3:0] o_symb_idx,
  output logic [6:0] o_slot_idx,
  output logic       o_busy,
  output logic       o_overrun
);

  localparam int unsigned BEAT_W = 8;
  localparam int unsigned RBG_W  = 4;
  localparam int unsigned SYMB_W = 4;
  localparam int unsigned SLOT_W = 7;
  localparam int unsigned GAP_W  = 4;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);
  localparam logic [RBG_W-1:0]  LAST_RBG  = RBG_W'(RBG_NUM - 1);
  localparam logic [SYMB_W-1:0] LAST_SYMB = SYMB_W'(SYMB_NUM - 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOT_NUM - 1);
  // Only meaningful when GAP_LEN > 0; the GAP state is never entered otherwise.
  localparam logic [GAP_W-1:0]  LAST_GAP  = GAP_W'(GAP_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_BURST,
    S_GAP
  } state_t;

  state_t              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [BEAT_W-1:0]   beat_nxt;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [RBG_W-1:0]    rbg_q, rbg_d;
  logic [SYMB_W-1:0]   symb_q, symb_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic                load_q, load_d;
  logic                vld_q, vld_d;
  logic                sop_q, sop_d;
  logic                eop_q, eop_d;
  logic                busy_q, busy_d;
  logic                ovr_q, ovr_d;

  // State and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      gap_q   <= '0;
      rbg_q   <= '0;
      symb_q  <= '0;
      slot_q  <= '0;
      load_q  <= 1'b0;
      vld_q   <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      gap_q   <= gap_d;
      rbg_q   <= rbg_d;
      symb_q  <= symb_d;
      slot_q  <= slot_d;
      load_q  <= load_d;
      vld_q   <= vld_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next state and next registered outputs.
  // beat_q holds the index of the beat being presented (vld_q=1) or of the
  // beat still waiting for ready (vld_q=0).
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    beat_nxt = beat_q;
    gap_d    = gap_q;
    rbg_d    = rbg_q;
    symb_d   = symb_q;
    slot_d   = slot_q;
    load_d   = 1'b0;
    vld_d    = 1'b0;
    sop_d    = 1'b0;
    eop_d    = 1'b0;

    // Overrun set has priority over clear
    if (i_sym_start && (state_q != S_IDLE)) begin
      ovr_d = 1'b1;
    end else if (i_clr_err) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end

    case (state_q)
      S_IDLE: begin
        if (i_sym_start && i_enable) begin
          state_d = S_LOAD;
          load_d  = 1'b1;
        end
      end

      S_LOAD: begin
        state_d = S_BURST;
        beat_d  = '0;
        vld_d   = i_rready;
        sop_d   = i_rready;
        eop_d   = i_rready && (LAST_BEAT == '0);
      end

      S_BURST: begin
        if (vld_q && eop_q) begin
          if ((rbg_q < LAST_RBG) && i_enable) begin
            rbg_d = rbg_q + RBG_W'(1);
            if (GAP_LEN == 0) begin
              state_d = S_LOAD;
              load_d  = 1'b1;
            end else begin
              state_d = S_GAP;
              gap_d   = '0;
            end
          end else begin
            // Symbol finished or abandoned: advance symbol/slot position
            state_d = S_IDLE;
            rbg_d   = '0;
            if (symb_q == LAST_SYMB) begin
              symb_d = '0;
              slot_d = (slot_q == LAST_SLOT) ? '0 : slot_q + SLOT_W'(1);
            end else begin
              symb_d = symb_q + SYMB_W'(1);
            end
          end
        end else begin
          beat_nxt = beat_q + BEAT_W'(vld_q);
          beat_d   = beat_nxt;
          vld_d    = i_rready;
          sop_d    = i_rready && (beat_nxt == '0);
          eop_d    = i_rready && (beat_nxt == LAST_BEAT);
        end
      end

      S_GAP: begin
        if (gap_q == LAST_GAP) begin
          state_d = S_LOAD;
          load_d  = 1'b1;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign o_rbg_load = load_q;
  assign o_rx_vld   = vld_q;
  assign o_rx_sop   = sop_q;
  assign o_rx_eop   = eop_q;
  assign o_rbg_idx  = rbg_q;
  assign o_symb_idx = symb_q;
  assign o_slot_idx = slot_q;
  assign o_busy     = busy_q;
  assign o_overrun  = ovr_q;

endmodule

// File: tb/tb_txdata_pkt_sched.sv
// Bench for txdata_pkt_sched: default-parameter instance for scheduling,
// backpressure, overrun, enable and reset scenarios; a small instance
// (2-beat packets, 2 RBGs, no gap) for symbol/slot wrap over a full frame.
module tb_txdata_pkt_sched;

  localparam int PKT  = 48;
  localparam int RBG  = 16;
  localparam int GAP  = 4;
  localparam int SYMB = 14;
  localparam int SLOT = 80;
  localparam int MAXC = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, en = 1'b0, st = 1'b0, rdy = 1'b0, clr = 1'b0;
  logic       ld, vld, sop, eop, busy, ovr;
  logic [3:0] rbg, symb;
  logic [6:0] slot;

  logic       rst2 = 1'b1, en2 = 1'b0, st2 = 1'b0, rdy2 = 1'b1, clr2 = 1'b0;
  logic       ld2, vld2, sop2, eop2, busy2, ovr2;
  logic [3:0] rbg2, symb2;
  logic [6:0] slot2;

  txdata_pkt_sched dut (
    .i_clk(clk), .i_reset(rst), .i_enable(en), .i_sym_start(st),
    .i_rready(rdy), .i_clr_err(clr),
    .o_rbg_load(ld), .o_rx_vld(vld), .o_rx_sop(sop), .o_rx_eop(eop),
    .o_rbg_idx(rbg), .o_symb_idx(symb), .o_slot_idx(slot),
    .o_busy(busy), .o_overrun(ovr)
  );

  txdata_pkt_sched #(
    .PKT_LEN(2), .RBG_NUM(2), .GAP_LEN(0), .SYMB_NUM(14), .SLOT_NUM(80)
  ) dut2 (
    .i_clk(clk), .i_reset(rst2), .i_enable(en2), .i_sym_start(st2),
    .i_rready(rdy2), .i_clr_err(clr2),
    .o_rbg_load(ld2), .o_rx_vld(vld2), .o_rx_sop(sop2), .o_rx_eop(eop2),
    .o_rbg_idx(rbg2), .o_symb_idx(symb2), .o_slot_idx(slot2),
    .o_busy(busy2), .o_overrun(ovr2)
  );

  int checks = 0;
  int errors = 0;
  int exp_symb = 0;
  int exp_slot = 0;
  int ex_last;

  bit       rdy_pat [MAXC];
  bit       ob_ld [MAXC], ob_vld [MAXC], ob_sop [MAXC], ob_eop [MAXC];
  bit       ob_busy [MAXC], ob_ovr [MAXC];
  bit [3:0] ob_rbg [MAXC], ob_symb [MAXC];
  bit       ex_ld [MAXC], ex_vld [MAXC], ex_sop [MAXC], ex_eop [MAXC];

  // One clock cycle on the main instance: drive after the edge, sample mid-cycle
  task automatic step(input bit r, input bit s, input bit e, input bit rd, input bit c);
    @(posedge clk);
    #1;
    rst = r; st = s; en = e; rdy = rd; clr = c;
    @(negedge clk);
  endtask

  task automatic step2(input bit r, input bit s, input bit e);
    @(posedge clk);
    #1;
    rst2 = r; st2 = s; en2 = e;
    @(negedge clk);
  endtask

  // Drive one symbol (start pulse at cycle 0) and record outputs per cycle
  task automatic run_symbol(input int ncyc, input int en_off, input int ovr_at, input int clr_at);
    for (int k = 0; k < ncyc; k++) begin
      step(1'b0, (k == 0) || (k == ovr_at), (k < en_off), rdy_pat[k], (k == clr_at));
      ob_ld[k] = ld;  ob_vld[k] = vld;  ob_sop[k] = sop;  ob_eop[k] = eop;
      ob_busy[k] = busy; ob_ovr[k] = ovr; ob_rbg[k] = rbg; ob_symb[k] = symb;
    end
  endtask

  // Reference schedule: load, then one beat on each cycle following a ready
  // cycle, gap after each eop, stop after the last RBG or once enable is low.
  task automatic model_symbol(input int en_off);
    int t, c, beats, te;
    for (int k = 0; k < MAXC; k++) begin
      ex_ld[k] = 0; ex_vld[k] = 0; ex_sop[k] = 0; ex_eop[k] = 0;
    end
    t = 1;
    te = 0;
    for (int p = 0; p < RBG; p++) begin
      ex_ld[t] = 1;
      c = t + 1;
      beats = 0;
      while (beats < PKT && c < MAXC) begin
        if (rdy_pat[c-1]) begin
          ex_vld[c] = 1;
          if (beats == 0) ex_sop[c] = 1;
          if (beats == PKT - 1) ex_eop[c] = 1;
          beats++;
          te = c;
        end
        c++;
      end
      if (p == RBG - 1 || te >= en_off) break;
      t = te + GAP + 1;
    end
    ex_last = te;
    exp_symb = exp_symb + 1;
    if (exp_symb == SYMB) begin
      exp_symb = 0;
      exp_slot = (exp_slot + 1) % SLOT;
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1, 1'b1, $urandom_range(0, 1) != 0, 1'b0);
      if (k >= 1) begin
        checks++;
        if ({ld, vld, sop, eop, rbg, symb, slot, busy, ovr} !== 22'd0) begin
          errors++;
          $display("FAIL reset_outputs cyc %0d: got %b want all zero", k,
                   {ld, vld, sop, eop, rbg, symb, slot, busy, ovr});
        end
      end
    end
  endtask

  task automatic test_nominal();
    int n_ld, n_vld, t_ld0, t_ld1, t_sop0, t_eop0;
    for (int k = 0; k < MAXC; k++) rdy_pat[k] = 1;
    model_symbol(MAXC);
    run_symbol(900, MAXC, -1, -1);
    n_ld = 0; n_vld = 0; t_ld0 = -1; t_ld1 = -1; t_sop0 = -1; t_eop0 = -1;
    for (int k = 0; k < 900; k++) begin
      checks++;
      if ({ob_ld[k], ob_vld[k], ob_sop[k], ob_eop[k]} !== {ex_ld[k], ex_vld[k], ex_sop[k], ex_eop[k]}) begin
        errors++;
        $display("FAIL nominal_frame cyc %0d: ld/vld/sop/eop got %b%b%b%b want %b%b%b%b", k,
                 ob_ld[k], ob_vld[k], ob_sop[k], ob_eop[k], ex_ld[k], ex_vld[k], ex_sop[k], ex_eop[k]);
      end
      if (ob_ld[k]) begin
        checks++;
        if (ob_rbg[k] !== 4'(n_ld)) begin
          errors++;
          $display("FAIL nominal_rbg_idx cyc %0d: got %0d want %0d", k, ob_rbg[k], n_ld);
        end
        if (n_ld == 0) t_ld0 = k;
        if (n_ld == 1) t_ld1 = k;
        n_ld++;
      end
      if (ob_vld[k]) n_vld++;
      if (ob_sop[k] && t_sop0 < 0) t_sop0 = k;
      if (ob_eop[k] && t_eop0 < 0) t_eop0 = k;
    end
    checks++;
    if ({t_ld0, t_sop0, t_eop0, t_ld1} !== {32'sd1, 32'sd2, 32'sd49, 32'sd54}) begin
      errors++;
      $display("FAIL nominal_latency: load/sop/eop/load2 got %0d/%0d/%0d/%0d want 1/2/49/54",
               t_ld0, t_sop0, t_eop0, t_ld1);
    end
    checks++;
    if (n_vld !== 768 || n_ld !== 16) begin
      errors++;
      $display("FAIL nominal_counts: vld %0d loads %0d want 768 16", n_vld, n_ld);
    end
    checks++;
    if ({ob_busy[899], ob_rbg[899], ob_symb[899]} !== {1'b0, 4'd0, 4'd1}) begin
      errors++;
      $display("FAIL nominal_end: busy %0d rbg %0d symb %0d want 0 0 1",
               ob_busy[899], ob_rbg[899], ob_symb[899]);
    end
  endtask

  task automatic test_backpressure();
    int n_beats, n_stall, t_eop0;
    for (int k = 0; k < MAXC; k++) rdy_pat[k] = !(k >= 12 && k <= 16);
    model_symbol(MAXC);
    run_symbol(910, MAXC, -1, -1);
    for (int k = 0; k < 910; k++) begin
      checks++;
      if ({ob_ld[k], ob_vld[k], ob_sop[k], ob_eop[k]} !== {ex_ld[k], ex_vld[k], ex_sop[k], ex_eop[k]}) begin
        errors++;
        $display("FAIL backpressure_frame cyc %0d: ld/vld/sop/eop got %b%b%b%b want %b%b%b%b", k,
                 ob_ld[k], ob_vld[k], ob_sop[k], ob_eop[k], ex_ld[k], ex_vld[k], ex_sop[k], ex_eop[k]);
      end
    end
    n_beats = 0; n_stall = 0; t_eop0 = -1;
    for (int k = 2; k < 60; k++) begin
      if (ob_vld[k] && t_eop0 < 0) n_beats++;
      if (ob_eop[k] && t_eop0 < 0) t_eop0 = k;
      if (k >= 13 && k <= 17 && ob_vld[k]) n_stall++;
    end
    checks++;
    if (n_stall !== 0 || ob_vld[12] !== 1'b1 || ob_vld[18] !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_stall: vld in stall window %0d, vld@12 %0d vld@18 %0d want 0 1 1",
               n_stall, ob_vld[12], ob_vld[18]);
    end
    checks++;
    if (n_beats !== 48 || t_eop0 !== 54) begin
      errors++;
      $display("FAIL backpressure_packet: beats %0d eop at %0d want 48 at 54", n_beats, t_eop0);
    end
    checks++;
    if (ob_symb[909] !== 4'(exp_symb)) begin
      errors++;
      $display("FAIL backpressure_symb: got %0d want %0d", ob_symb[909], exp_symb);
    end
  endtask

  task automatic test_random_ready();
    int ncyc;
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < MAXC; k++) rdy_pat[k] = ($urandom_range(0, 3) != 0);
      model_symbol(MAXC);
      ncyc = (ex_last + 6 < MAXC) ? ex_last + 6 : MAXC;
      run_symbol(ncyc, MAXC, -1, -1);
      for (int k = 0; k < ncyc; k++) begin
        checks++;
        if ({ob_ld[k], ob_vld[k], ob_sop[k], ob_eop[k]} !== {ex_ld[k], ex_vld[k], ex_sop[k], ex_eop[k]}) begin
          errors++;
          $display("FAIL random_frame sym %0d cyc %0d: ld/vld/sop/eop got %b%b%b%b want %b%b%b%b", s, k,
                   ob_ld[k], ob_vld[k], ob_sop[k], ob_eop[k], ex_ld[k], ex_vld[k], ex_sop[k], ex_eop[k]);
        end
      end
      checks++;
      if ({ob_busy[ncyc-1], ob_symb[ncyc-1]} !== {1'b0, 4'(exp_symb)}) begin
        errors++;
        $display("FAIL random_end sym %0d: busy %0d symb %0d want 0 %0d", s,
                 ob_busy[ncyc-1], ob_symb[ncyc-1], exp_symb);
      end
    end
  endtask

  task automatic test_overrun();
    for (int k = 0; k < MAXC; k++) rdy_pat[k] = 1;
    // Start while disabled in IDLE: ignored and not an overrun
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({ld, busy, ovr} !== 3'b000) begin
      errors++;
      $display("FAIL disabled_start: ld/busy/ovr got %b want 000", {ld, busy, ovr});
    end
    // Start during BURST of RBG 3 (load at 160, beats 161..208)
    model_symbol(MAXC);
    run_symbol(900, MAXC, 180, -1);
    for (int k = 0; k < 900; k++) begin
      checks++;
      if ({ob_ld[k], ob_vld[k], ob_sop[k], ob_eop[k]} !== {ex_ld[k], ex_vld[k], ex_sop[k], ex_eop[k]}) begin
        errors++;
        $display("FAIL overrun_frame cyc %0d: ld/vld/sop/eop got %b%b%b%b want %b%b%b%b", k,
                 ob_ld[k], ob_vld[k], ob_sop[k], ob_eop[k], ex_ld[k], ex_vld[k], ex_sop[k], ex_eop[k]);
      end
    end
    checks++;
    if ({ob_ovr[180], ob_ovr[181], ob_ovr[899]} !== 3'b011) begin
      errors++;
      $display("FAIL overrun_set: ovr@180/181/899 got %b want 011", {ob_ovr[180], ob_ovr[181], ob_ovr[899]});
    end
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (ovr !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear: got %0d want 0", ovr);
    end
    // Set and clear in the same cycle: set wins
    model_symbol(MAXC);
    run_symbol(900, MAXC, 100, 100);
    checks++;
    if ({ob_ovr[100], ob_ovr[101]} !== 2'b01) begin
      errors++;
      $display("FAIL overrun_set_vs_clear: ovr@100/101 got %b want 01", {ob_ovr[100], ob_ovr[101]});
    end
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (ovr !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear2: got %0d want 0", ovr);
    end
  endtask

  task automatic test_enable_drop();
    int n_ld, late_ld;
    for (int k = 0; k < MAXC; k++) rdy_pat[k] = 1;
    // RBG 5 loads at 266, its beat 20 is at cycle 287
    model_symbol(287);
    run_symbol(400, 287, -1, -1);
    n_ld = 0; late_ld = 0;
    for (int k = 0; k < 400; k++) begin
      checks++;
      if ({ob_ld[k], ob_vld[k], ob_sop[k], ob_eop[k]} !== {ex_ld[k], ex_vld[k], ex_sop[k], ex_eop[k]}) begin
        errors++;
        $display("FAIL enable_drop_frame cyc %0d: ld/vld/sop/eop got %b%b%b%b want %b%b%b%b", k,
                 ob_ld[k], ob_vld[k], ob_sop[k], ob_eop[k], ex_ld[k], ex_vld[k], ex_sop[k], ex_eop[k]);
      end
      if (ob_ld[k]) n_ld++;
      if (ob_ld[k] && k > 314) late_ld++;
    end
    checks++;
    if (n_ld !== 6 || late_ld !== 0 || ob_eop[314] !== 1'b1) begin
      errors++;
      $display("FAIL enable_drop_sched: loads %0d late loads %0d eop@314 %0d want 6 0 1",
               n_ld, late_ld, ob_eop[314]);
    end
    checks++;
    if ({ob_busy[399], ob_rbg[399], ob_symb[399]} !== {1'b0, 4'd0, 4'(exp_symb)}) begin
      errors++;
      $display("FAIL enable_drop_end: busy %0d rbg %0d symb %0d want 0 0 %0d",
               ob_busy[399], ob_rbg[399], ob_symb[399], exp_symb);
    end
  endtask

  task automatic test_reset_mid();
    // Beat 30 of RBG 0 is presented at cycle 32
    for (int k = 0; k <= 32; k++) step(k == 32, k == 0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (vld !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_pre: vld %0d busy %0d want 1 1", vld, busy);
    end
    // First cycle after reset: outputs cleared, and a start is accepted
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    exp_symb = 0;
    exp_slot = 0;
    checks++;
    if ({ld, vld, sop, eop, rbg, symb, slot, busy, ovr} !== 22'd0) begin
      errors++;
      $display("FAIL reset_mid_clear: got %b want all zero", {ld, vld, sop, eop, rbg, symb, slot, busy, ovr});
    end
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({ld, rbg, symb, busy} !== {1'b1, 4'd0, 4'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_mid_restart: ld %0d rbg %0d symb %0d busy %0d want 1 0 0 1", ld, rbg, symb, busy);
    end
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_wrap();
    int waited;
    int t_ld [$];
    int t_eop [$];
    step2(1'b1, 1'b0, 1'b0);
    step2(1'b1, 1'b0, 1'b0);
    for (int n = 1; n <= 14 + 14 * 80; n++) begin
      step2(1'b0, 1'b1, 1'b1);
      waited = 0;
      do begin
        step2(1'b0, 1'b0, 1'b1);
        waited++;
        if (n == 1 && ld2) t_ld.push_back(waited);
        if (n == 1 && eop2) t_eop.push_back(waited);
      end while (busy2 && waited < 40);
      checks++;
      if (busy2 !== 1'b0) begin
        errors++;
        $display("FAIL wrap_timeout sym %0d: still busy after %0d cycles", n, waited);
      end
      checks++;
      if ({symb2, slot2} !== {4'(n % 14), 7'((n / 14) % 80)}) begin
        errors++;
        $display("FAIL wrap_counters sym %0d: symb %0d slot %0d want %0d %0d",
                 n, symb2, slot2, n % 14, (n / 14) % 80);
      end
      if (n == 1) begin
        // No gap: second load directly follows the first eop
        checks++;
        if (t_ld.size() != 2 || t_eop.size() != 2) begin
          errors++;
          $display("FAIL wrap_nogap_count: loads %0d eops %0d want 2 2", t_ld.size(), t_eop.size());
        end else if ({t_ld[0], t_eop[0], t_ld[1], t_eop[1]} !== {32'sd1, 32'sd3, 32'sd4, 32'sd6}) begin
          errors++;
          $display("FAIL wrap_nogap_timing: load/eop/load/eop got %0d/%0d/%0d/%0d want 1/3/4/6",
                   t_ld[0], t_eop[0], t_ld[1], t_eop[1]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_random_ready();
    test_overrun();
    test_enable_drop();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
